data_producer: RTL
==================

# data_producer

Source-side block for the clock-domain-crossing buffer. Runs on the fast clock, generates either the 16-bit Fibonacci sequence or a countdown timer sequence, and presents each value on `data_1` / `data_1_en`. Honors the buffer's `buffer_full` backpressure so that no value is ever written into a full buffer or dropped. Signals sequence completion to the controlling logic.

## Interface
- `PACE_DIV`, default 1: clk_1 cycles between successive emission opportunities; range 1..65535.
- `clk_1`  in  1  fast system clock; sole clock of the block.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a sequence when idle.
- `stop`  in  1  one-cycle pulse; aborts a running sequence.
- `mode`  in  1  0 = Fibonacci, 1 = Timer; sampled only on an accepted `start`.
- `timer_load`  in  16  Timer start value; sampled only on an accepted `start`.
- `buffer_full`  in  1  backpressure from the buffer; 1 = no write accepted this cycle.
- `data_1_en`  out  1  write strobe into the buffer; combinational.
- `data_1`  out  16  value being emitted; registered.
- `busy`  out  1  1 while a sequence is running.
- `done`  out  1  one-cycle pulse after the final value of a sequence is emitted.

## Operation
- States: IDLE, RUN.
- IDLE:
  - An accepted `start` loads the generator and enters RUN.
  - `start` and `stop` asserted together in IDLE: `stop` wins and the block stays IDLE.
- Fibonacci load:
  - `cur` = 0 and `nxt` = 1.
  - Each emission sends `cur`, then updates `cur` to `nxt` and `nxt` to `cur + nxt`, computed 17 bits wide.
  - If the 17-bit `nxt` exceeds 65535 at emission time, that emission is the last.
  - Resulting sequence is 0, 1, 1, 2, …, 46368: 25 values.
- Timer load:
  - `cur` = `timer_load`.
  - Each emission sends `cur`, then decrements it.
  - The emission of 0 is the last, giving `timer_load` + 1 values.
  - `timer_load` = 0 emits a single 0.
- Emission condition: `data_1_en` = RUN ∧ pace counter == 0 ∧ ¬`buffer_full` ∧ ¬`stop`.
- `data_1` always shows `cur` and is stable while `data_1_en` is low.
- Pace counter:
  - Reloads to `PACE_DIV`-1 on each emission.
  - Decrements while nonzero in RUN.
  - Holds at 0 while stalled by `buffer_full`.
- Last emission:
  - Next state is IDLE.
  - `done` pulses high in the following cycle.
- `stop` in RUN:
  - Suppresses any emission in that cycle.
  - Next state is IDLE; no `done` pulse.
- `start` while in RUN is ignored. `mode` and `timer_load` changes during RUN have no effect.

## Timing
- Reset values:
  - State IDLE.
  - `data_1` = 0, `data_1_en` = 0, `busy` = 0, `done` = 0.
  - `cur` = 0, `nxt` = 1, pace counter = 0.
- Reset has priority over `start` and `stop`. A reset mid-sequence discards all progress; no `done` pulse.
- `start` accepted at edge k:
  - `busy` = 1 and `data_1` = first value from edge k.
  - First `data_1_en` possible in cycle k..k+1.
- Backpressure has zero latency:
  - `buffer_full` high in a cycle forces `data_1_en` low in that same cycle.
  - The write happens on the edge at which `data_1_en` is sampled high.
  - No over-write, no duplicate, no skipped value.
- With `PACE_DIV` = 1 and no stall, the block emits one value per cycle.
- Final emission at edge m: `busy` = 0 and `done` = 1 for cycle m..m+1 only.

## Structure
- Shared package holds:
  - State enum (IDLE, RUN).
  - Mode constants (MODE_FIB = 0, MODE_TIMER = 1).
  - Data width constant (16) and Fibonacci last value (46368), shared with the consumer-side checker.
- One sub-module, `pace_counter`: reload / decrement / hold, with a zero flag.
- The generator datapath and the FSM stay in `data_producer`.

## Test plan
- Fibonacci, `PACE_DIV` = 1, `buffer_full` held 0 → 25 consecutive strobes carrying 0, 1, 1, 2, 3, 5 … 46368, then one `done` pulse; `busy` low afterwards.
- Timer, `timer_load` = 3, `PACE_DIV` = 4 → strobes with 3, 2, 1, 0 exactly 4 cycles apart, then `done`; `timer_load` = 0 → a single 0 then `done`.
- Fibonacci with `buffer_full` raised for 5 cycles after the value 8 → no strobe while full; next strobe carries 13; full sequence intact with no gaps or repeats.
- `stop` pulsed in the cycle where value 21 would be emitted → 21 is not strobed; IDLE next cycle, no `done`. `start` + `stop` together in IDLE → stays IDLE.
- `rst` asserted mid-Timer run (`timer_load` = 100, after value 95) → all outputs at reset values next cycle. A new `start` with `mode` = 0 restarts cleanly at 0.
- `start` pulsed again during RUN, and `timer_load` changed during RUN → current sequence unaffected.

Source files
------------

// File: rtl/data_producer_pkg.sv
// rtl/data_producer_pkg.sv - shared types and constants for the CDC buffer producer/checker
package data_producer_pkg;

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] FIB_LAST = 16'd46368;

  localparam logic MODE_FIB   = 1'b0;
  localparam logic MODE_TIMER = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/data_producer_pace_counter.sv
// rtl/data_producer_pace_counter.sv - emission pacing counter: reload / decrement / hold with zero flag
module pace_counter #(
  parameter int PACE_DIV = 1
) (
  input  logic clk_1,
  input  logic rst,
  input  logic clear,
  input  logic reload,
  input  logic enable,
  output logic zero
);

  localparam logic [15:0] RELOAD_VAL = 16'(PACE_DIV - 1);

  logic [15:0] cnt;

  // Clearing on a new start lets the first value go out immediately even if
  // the previous sequence left the counter mid-interval.
  always_ff @(posedge clk_1) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (reload) begin
      cnt <= RELOAD_VAL;
    end else if (enable && (cnt != 16'd0)) begin
      cnt <= cnt - 16'd1;
    end
  end

  assign zero = (cnt == 16'd0);

endmodule

// File: rtl/data_producer.sv
// rtl/data_producer.sv - Fibonacci / countdown source with buffer_full backpressure
module data_producer
  import data_producer_pkg::*;
#(
  parameter int PACE_DIV = 1
) (
  input  logic              clk_1,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [DATA_W-1:0] timer_load,
  input  logic              buffer_full,
  output logic              data_1_en,
  output logic [DATA_W-1:0] data_1,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic              mode_r;
  logic [DATA_W-1:0] cur;
  logic [DATA_W:0]   nxt;
  logic              pace_zero;
  logic              accept_start;
  logic              last_emit;

  assign accept_start = (state == IDLE) && start && !stop;
  assign data_1_en    = (state == RUN) && pace_zero && !buffer_full && !stop;
  assign data_1       = cur;

  // Fibonacci ends once the following term no longer fits in the data width.
  assign last_emit = (mode_r == MODE_TIMER) ? (cur == '0) : nxt[DATA_W];

  pace_counter #(.PACE_DIV(PACE_DIV)) u_pace (
    .clk_1  (clk_1),
    .rst    (rst),
    .clear  (accept_start),
    .reload (data_1_en),
    .enable (state == RUN),
    .zero   (pace_zero)
  );

  always_ff @(posedge clk_1) begin
    if (rst) begin
      state  <= IDLE;
      mode_r <= MODE_FIB;
      cur    <= '0;
      nxt    <= 17'd1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_start) begin
            state  <= RUN;
            busy   <= 1'b1;
            mode_r <= mode;
            cur    <= (mode == MODE_TIMER) ? timer_load : '0;
            nxt    <= 17'd1;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (data_1_en) begin
            if (last_emit) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (mode_r == MODE_TIMER) begin
              cur <= cur - 16'd1;
            end else begin
              cur <= nxt[DATA_W-1:0];
              nxt <= {1'b0, cur} + nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
